bcd_timekeeper: RTL and testbench
=================================

Name: bcd_timekeeper

Overview:
Parametrised successor to the top-level MM:SS current-time counter. Keeps time as true packed BCD over N_FIELDS digit pairs (SS, MM, optional HH) and supports validated load. Also holds an alarm register with an arm/ring/acknowledge state machine. Feeds the display scanner and the alarm/mini-game logic in the top level.

Parameters:
N_FIELDS, 2, number of BCD digit pairs (2 = MM:SS, 3 = HH:MM:SS); legal 1..3.
TOP_MOD, 60, modulus of the most-significant field (60 or 24 for hours); lower fields are fixed at 60.
PRESCALE, 1, tick_en pulses per one time increment; legal 1..1023.
RING_LEN, 60, increments the alarm rings before auto-stop; 0 = rings until ack.
SNOOZE_LEN, 300, increments spent in SNOOZE (used only with SNOOZE_EN).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick_en  in  1  single-cycle base tick (e.g. 1 Hz strobe)
load  in  1  load time from load_value
load_value  in  8*N_FIELDS  packed BCD time, field 0 = [7:0] seconds
alarm_load  in  1  load alarm register from alarm_value
alarm_value  in  8*N_FIELDS  packed BCD alarm time
arm  in  1  level; 1 = alarm enabled
ack  in  1  single-cycle acknowledge, stops ringing
snooze  in  1  single-cycle snooze request
time_bcd  out  8*N_FIELDS  current time, packed BCD
alarm_bcd  out  8*N_FIELDS  stored alarm time
ring  out  1  alarm ringing
wrap  out  1  one-cycle pulse when the full time wraps to all zeros
load_err  out  1  one-cycle pulse on rejected load/alarm_load

Behaviour:
- Reset (synchronous): time_bcd = 0, alarm_bcd = 0, prescaler = 0, state IDLE, ring = 0, wrap = 0, load_err = 0.
- Prescaler: counts tick_en pulses; at count PRESCALE-1 it issues an internal inc and returns to 0.
- Increment on inc:
  - Field 0 ones digit +1. At 9 it clears and tens +1.
  - Field of value mod-1 clears to 00 and carries into the next field.
  - Top field wraps at TOP_MOD-1 -> 00. If all fields wrap, wrap pulses on the same edge time_bcd becomes 0.
  - Arithmetic is per-nibble BCD only; binary-coded values (e.g. 0x3B) never appear.
- Load validation: a value is invalid if any nibble > 9, any lower field tens > 5, or the top field >= TOP_MOD.
  - Invalid: register unchanged, load_err pulses next edge.
  - Valid load: time_bcd = load_value next edge and the prescaler clears.
  - alarm_load: same validation, writes alarm_bcd only.
- Priority per cycle: reset > load > inc. Load and inc in the same cycle: the load wins and the inc is dropped. load and alarm_load together are independent, each validated separately.
- upd flag: registered, 1 for exactly one cycle after time_bcd changes by inc or valid load.
- Alarm FSM:
  - IDLE -> ARMED when arm = 1.
  - ARMED -> RINGING when upd = 1 and time_bcd == alarm_bcd; ring asserts on that edge. Latency: the inc edge updates time, and ring is set on the following edge.
  - RINGING -> ARMED on ack, or after RING_LEN incs (ring counter counts inc while RINGING).
  - Any state -> IDLE when arm = 0. ring = 0 in IDLE.
  - ack outside RINGING is ignored.
- Re-trigger: time equal to alarm without upd never rings, so an ack followed by no time change cannot retrigger.
- alarm_load during RINGING: the new alarm is stored and ringing continues.

Optional Feature:
- SNOOZE_EN defined:
  - snooze in RINGING -> SNOOZE: ring = 0, snooze counter cleared.
  - After SNOOZE_LEN incs -> RINGING with the ring counter cleared.
  - ack in SNOOZE -> ARMED; arm = 0 -> IDLE.
  - Simultaneous ack and snooze: ack wins.
- SNOOZE_EN undefined: snooze port present but ignored, SNOOZE state not generated.

Decomposition:
- Shared package: BCD nibble max (9), tens max (5), field width (8), state encoding (IDLE, ARMED, RINGING, SNOOZE), MAX_FIELDS = 3.
- Sub-module bcd_field_counter: one digit pair with parameter MOD, inputs inc/load/load_val, outputs value and carry. Instantiated N_FIELDS times with generate.
- Validation and the FSM live in bcd_timekeeper.

Test Plan:
- N_FIELDS=2, load 0x5959, one inc -> time_bcd = 0x0000, wrap = 1 for one cycle.
- Load time 0x0959, inc -> time_bcd = 0x1000 (BCD carry, not 0x095A).
- Load 0x6A00 -> load_err = 1 for one cycle, time_bcd unchanged. N_FIELDS=3, TOP_MOD=24, load 0x240000 -> load_err = 1.
- load 0x1234 asserted in the same cycle as inc -> time_bcd = 0x1234, no increment applied.
- arm = 1, alarm 0x0005, time 0x0004, inc -> ring = 1 two edges after the inc. With RING_LEN=3, three more incs -> ring = 0, state ARMED. Separately, ack mid-ring -> ring = 0 next edge with no retrigger.
- reset asserted while RINGING -> next edge: ring = 0, time_bcd = 0, alarm_bcd = 0, IDLE. With SNOOZE_EN and SNOOZE_LEN=2: snooze -> ring = 0, two incs -> ring = 1.

Source files
------------

// File: rtl/bcd_timekeeper_pkg.sv
// Shared constants, alarm state encoding and BCD field validation for bcd_timekeeper.
package bcd_timekeeper_pkg;

  localparam int BCD_MAX    = 9;
  localparam int TENS_MAX   = 5;
  localparam int FIELD_W    = 8;
  localparam int MAX_FIELDS = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_t;

  // True when v is a legal packed-BCD digit pair strictly below mod.
  function automatic logic field_valid(input logic [FIELD_W-1:0] v, input int unsigned mod);
    logic [3:0]  tens;
    logic [3:0]  ones;
    int unsigned dec;
    tens = v[7:4];
    ones = v[3:0];
    dec  = 32'(tens) * 32'd10 + 32'(ones);
    field_valid = (tens <= 4'(BCD_MAX)) && (ones <= 4'(BCD_MAX)) &&
                  ((mod != 32'd60) || (tens <= 4'(TENS_MAX))) && (dec < mod);
  endfunction

endpackage

// File: rtl/bcd_timekeeper_field_counter.sv
// One packed-BCD digit pair counting 00..MOD-1 with load and a combinational carry-out.
module bcd_field_counter
  import bcd_timekeeper_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_val,
  output logic [FIELD_W-1:0] value,
  output logic               carry
);

  localparam logic [3:0] MAX_TENS = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MOD - 1) % 10);

  logic [FIELD_W-1:0] r_value;
  logic               w_at_max;

  assign w_at_max = (r_value == {MAX_TENS, MAX_ONES});
  assign carry    = inc & w_at_max;
  assign value    = r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= load_val;
    end else if (inc) begin
      if (w_at_max)
        r_value <= '0;
      else if (r_value[3:0] == 4'(BCD_MAX))
        r_value <= {r_value[7:4] + 4'd1, 4'd0};
      else
        r_value <= {r_value[7:4], r_value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/bcd_timekeeper.sv
// Packed-BCD timekeeper with validated loads and an alarm arm/ring/ack FSM.
// Optional snooze state is built only when SNOOZE_EN is defined.
module bcd_timekeeper
  import bcd_timekeeper_pkg::*;
#(
  parameter int N_FIELDS   = 2,
  parameter int TOP_MOD    = 60,
  parameter int PRESCALE   = 1,
  parameter int RING_LEN   = 60,
  parameter int SNOOZE_LEN = 300
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick_en,
  input  logic                        load,
  input  logic [FIELD_W*N_FIELDS-1:0] load_value,
  input  logic                        alarm_load,
  input  logic [FIELD_W*N_FIELDS-1:0] alarm_value,
  input  logic                        arm,
  input  logic                        ack,
  input  logic                        snooze,
  output logic [FIELD_W*N_FIELDS-1:0] time_bcd,
  output logic [FIELD_W*N_FIELDS-1:0] alarm_bcd,
  output logic                        ring,
  output logic                        wrap,
  output logic                        load_err
);

  localparam int TW   = FIELD_W * N_FIELDS;
  localparam int RC_W = $clog2(RING_LEN + 2);
  localparam int SC_W = $clog2(SNOOZE_LEN + 2);

  logic [TW-1:0]       r_alarm;
  logic [9:0]          r_presc;
  logic                r_upd;
  logic                r_wrap;
  logic                r_load_err;
  alarm_state_t        r_state;
  alarm_state_t        w_state_next;
  logic [RC_W-1:0]     r_ring_cnt;
  logic [RC_W-1:0]     w_ring_cnt_next;
  logic                w_presc_wrap;
  logic                w_inc;
  logic                w_inc_eff;
  logic                w_load_ok;
  logic                w_aload_ok;
  logic [N_FIELDS-1:0] w_fvalid;
  logic [N_FIELDS-1:0] w_afvalid;
  logic [N_FIELDS:0]   w_cin;

  assign w_presc_wrap = (r_presc == 10'(PRESCALE - 1));
  assign w_inc        = tick_en & w_presc_wrap;
  // Any load request in the same cycle swallows the increment.
  assign w_inc_eff    = w_inc & ~load;
  assign w_cin[0]     = w_inc_eff;
  assign w_load_ok    = load & (&w_fvalid);
  assign w_aload_ok   = alarm_load & (&w_afvalid);

  generate
    for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_field
      localparam int FMOD = (gi == N_FIELDS - 1) ? TOP_MOD : 60;
      assign w_fvalid[gi]  = field_valid(load_value[gi*FIELD_W +: FIELD_W], FMOD);
      assign w_afvalid[gi] = field_valid(alarm_value[gi*FIELD_W +: FIELD_W], FMOD);
      bcd_field_counter #(.MOD(FMOD)) u_field (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_cin[gi]),
        .load     (w_load_ok),
        .load_val (load_value[gi*FIELD_W +: FIELD_W]),
        .value    (time_bcd[gi*FIELD_W +: FIELD_W]),
        .carry    (w_cin[gi+1])
      );
    end
  endgenerate

`ifdef SNOOZE_EN
  logic [SC_W-1:0] r_snz_cnt;
  logic [SC_W-1:0] w_snz_cnt_next;
`else
  logic [SC_W:0] w_unused_snooze;
  assign w_unused_snooze = {snooze, SC_W'(SNOOZE_LEN)};
`endif

  always_comb begin
    w_state_next    = r_state;
    w_ring_cnt_next = r_ring_cnt;
`ifdef SNOOZE_EN
    w_snz_cnt_next  = r_snz_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (arm) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm) begin
          w_state_next = ST_IDLE;
        end else if (r_upd && (time_bcd == r_alarm)) begin
          w_state_next    = ST_RINGING;
          w_ring_cnt_next = '0;
        end
      end
      ST_RINGING: begin
        if (!arm) begin
          w_state_next = ST_IDLE;
        end else if (ack) begin
          w_state_next = ST_ARMED;
`ifdef SNOOZE_EN
        end else if (snooze) begin
          w_state_next   = ST_SNOOZE;
          w_snz_cnt_next = '0;
`endif
        end else if (w_inc_eff && (RING_LEN != 0)) begin
          if (r_ring_cnt == RC_W'(RING_LEN - 1))
            w_state_next = ST_ARMED;
          else
            w_ring_cnt_next = r_ring_cnt + 1'b1;
        end
      end
`ifdef SNOOZE_EN
      ST_SNOOZE: begin
        if (!arm) begin
          w_state_next = ST_IDLE;
        end else if (ack) begin
          w_state_next = ST_ARMED;
        end else if (w_inc_eff) begin
          if (r_snz_cnt == SC_W'(SNOOZE_LEN - 1)) begin
            w_state_next    = ST_RINGING;
            w_ring_cnt_next = '0;
          end else begin
            w_snz_cnt_next = r_snz_cnt + 1'b1;
          end
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alarm    <= '0;
      r_presc    <= '0;
      r_upd      <= 1'b0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
      r_state    <= ST_IDLE;
      r_ring_cnt <= '0;
    end else begin
      if (w_aload_ok) r_alarm <= alarm_value;
      if (w_load_ok)
        r_presc <= '0;
      else if (tick_en)
        r_presc <= w_presc_wrap ? 10'd0 : r_presc + 10'd1;
      r_upd      <= w_load_ok | w_inc_eff;
      r_wrap     <= w_cin[N_FIELDS];
      r_load_err <= (load & ~w_load_ok) | (alarm_load & ~w_aload_ok);
      r_state    <= w_state_next;
      r_ring_cnt <= w_ring_cnt_next;
    end
  end

`ifdef SNOOZE_EN
  always_ff @(posedge clk) begin
    if (reset) r_snz_cnt <= '0;
    else       r_snz_cnt <= w_snz_cnt_next;
  end
`endif

  assign alarm_bcd = r_alarm;
  assign ring      = (r_state == ST_RINGING);
  assign wrap      = r_wrap;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Randomized + directed bench for bcd_timekeeper against a seconds-count reference model.
// Snooze expectations follow SNOOZE_EN when the bench is built with it.
module tb_bcd_timekeeper;

  localparam int PRE     = 2;
  localparam int RLEN    = 3;
  localparam int SLEN    = 2;
  localparam int MODULUS = 3600;
  localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_SNZ = 3;
`ifdef SNOOZE_EN
  localparam bit SN_EN = 1'b1;
`else
  localparam bit SN_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        tick_en = 1'b0, load = 1'b0, alarm_load = 1'b0;
  logic        arm = 1'b0, ack = 1'b0, snooze = 1'b0;
  logic [15:0] load_value = '0, alarm_value = '0;
  logic [15:0] time_bcd, alarm_bcd;
  logic        ring, wrap, load_err;

  logic        t3_tick = 1'b0, t3_load = 1'b0;
  logic [23:0] t3_lv = '0;
  logic [23:0] time3, alarm3;
  logic        ring3, wrap3, err3;

  int n_checks = 0, n_err = 0;

  // Reference model state: time/alarm held as plain seconds counts.
  int m_t, m_a, m_presc, m_st, m_rung, m_snz;
  bit m_upd, m_wrap, m_err;

  always #5 clk = ~clk;

  bcd_timekeeper #(.N_FIELDS(2), .TOP_MOD(60), .PRESCALE(PRE), .RING_LEN(RLEN), .SNOOZE_LEN(SLEN)) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .load(load), .load_value(load_value),
    .alarm_load(alarm_load), .alarm_value(alarm_value), .arm(arm), .ack(ack), .snooze(snooze),
    .time_bcd(time_bcd), .alarm_bcd(alarm_bcd), .ring(ring), .wrap(wrap), .load_err(load_err)
  );

  bcd_timekeeper #(.N_FIELDS(3), .TOP_MOD(24), .PRESCALE(1), .RING_LEN(0), .SNOOZE_LEN(SLEN)) dut3 (
    .clk(clk), .reset(reset), .tick_en(t3_tick), .load(t3_load), .load_value(t3_lv),
    .alarm_load(1'b0), .alarm_value(24'h0), .arm(1'b0), .ack(1'b0), .snooze(1'b0),
    .time_bcd(time3), .alarm_bcd(alarm3), .ring(ring3), .wrap(wrap3), .load_err(err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int t);
    int mm, ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit valid16(input logic [15:0] v);
    return (v[3:0] <= 9) && (v[7:4] <= 5) && (v[11:8] <= 9) && (v[15:12] <= 5);
  endfunction

  task automatic model_step();
    bit inc, lok, aok, inc_eff;
    if (reset) begin
      m_t = 0; m_a = 0; m_presc = 0; m_st = S_IDLE; m_rung = 0; m_snz = 0;
      m_upd = 0; m_wrap = 0; m_err = 0;
      return;
    end
    inc     = tick_en && (m_presc == PRE - 1);
    lok     = load && valid16(load_value);
    aok     = alarm_load && valid16(alarm_value);
    inc_eff = inc && !load;
    m_err   = (load && !lok) || (alarm_load && !aok);
    m_wrap  = inc_eff && ((m_t + 1) % MODULUS == 0);
    case (m_st)
      S_IDLE:  if (arm) m_st = S_ARMED;
      S_ARMED: begin
        if (!arm) m_st = S_IDLE;
        else if (m_upd && m_t == m_a) begin m_st = S_RING; m_rung = 0; end
      end
      S_RING: begin
        if (!arm) m_st = S_IDLE;
        else if (ack) m_st = S_ARMED;
        else if (SN_EN && snooze) begin m_st = S_SNZ; m_snz = 0; end
        else if (inc_eff) begin
          m_rung++;
          if (RLEN != 0 && m_rung == RLEN) m_st = S_ARMED;
        end
      end
      default: begin
        if (!arm) m_st = S_IDLE;
        else if (ack) m_st = S_ARMED;
        else if (inc_eff) begin
          m_snz++;
          if (m_snz == SLEN) begin m_st = S_RING; m_rung = 0; end
        end
      end
    endcase
    if (lok) m_t = bcd2int(load_value);
    else if (inc_eff) m_t = (m_t + 1) % MODULUS;
    if (aok) m_a = bcd2int(alarm_value);
    if (lok) m_presc = 0;
    else if (tick_en) m_presc = (m_presc + 1) % PRE;
    m_upd = lok || inc_eff;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, ".time"},  32'(time_bcd),  32'(int2bcd(m_t)));
    check({tag, ".alarm"}, 32'(alarm_bcd), 32'(int2bcd(m_a)));
    check({tag, ".ring"},  32'(ring),      32'(m_st == S_RING));
    check({tag, ".wrap"},  32'(wrap),      32'(m_wrap));
    check({tag, ".err"},   32'(load_err),  32'(m_err));
    $display("%-6s t=%0t rst=%0b tick=%0b ld=%0b lv=%h al=%0b av=%h arm=%0b ack=%0b snz=%0b -> time=%h alarm=%h ring=%0b wrap=%0b err=%0b",
             tag, $time, reset, tick_en, load, load_value, alarm_load, alarm_value, arm, ack, snooze,
             time_bcd, alarm_bcd, ring, wrap, load_err);
  endtask

  task automatic cyc(input string tag, input bit t, input bit ld, input logic [15:0] lv,
                     input bit al, input logic [15:0] av, input bit ak, input bit sz);
    tick_en = t; load = ld; load_value = lv; alarm_load = al; alarm_value = av; ack = ak; snooze = sz;
    step(tag);
    tick_en = 0; load = 0; alarm_load = 0; ack = 0; snooze = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 0, 0, 16'h0, 0, 16'h0, 0, 0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) cyc("tick", 1, 0, 16'h0, 0, 16'h0, 0, 0);
  endtask

  initial begin
    reset = 1;
    idle(2);
    check("rst.time", 32'(time_bcd), 32'h0);
    check("rst.ring", 32'(ring), 32'h0);
    reset = 0;

    // Three-field 24h instance: directed checks.
    t3_load = 1; t3_lv = 24'h240000;
    idle(1);
    check("h24.err", 32'(err3), 32'h1);
    check("h24.time", 32'(time3), 32'h0);
    t3_load = 0;
    idle(1);
    check("h24.err_clr", 32'(err3), 32'h0);
    t3_load = 1; t3_lv = 24'h235959;
    idle(1);
    check("h24.load", 32'(time3), 32'h235959);
    t3_load = 0; t3_tick = 1;
    idle(1);
    check("h24.wrap_time", 32'(time3), 32'h0);
    check("h24.wrap", 32'(wrap3), 32'h1);
    t3_tick = 0; t3_load = 1; t3_lv = 24'h091959;
    idle(1);
    t3_load = 0; t3_tick = 1;
    idle(1);
    check("h24.carry", 32'(time3), 32'h092000);
    t3_tick = 0;

    // Two-field instance: directed test-plan scenarios.
    cyc("ld5959", 0, 1, 16'h5959, 0, 16'h0, 0, 0);
    tick(2);
    check("wrap.time", 32'(time_bcd), 32'h0000);
    check("wrap.pulse", 32'(wrap), 32'h1);
    idle(1);
    check("wrap.clr", 32'(wrap), 32'h0);

    cyc("ld0959", 0, 1, 16'h0959, 0, 16'h0, 0, 0);
    tick(2);
    check("bcd_carry", 32'(time_bcd), 32'h1000);

    cyc("ld6A00", 0, 1, 16'h6A00, 0, 16'h0, 0, 0);
    check("bad.err", 32'(load_err), 32'h1);
    check("bad.time", 32'(time_bcd), 32'h1000);
    idle(1);
    check("bad.err_clr", 32'(load_err), 32'h0);

    tick(1);
    cyc("ldinc", 1, 1, 16'h1234, 0, 16'h0, 0, 0);
    check("ld_vs_inc", 32'(time_bcd), 32'h1234);

    arm = 1;
    cyc("alarm", 0, 1, 16'h0004, 1, 16'h0005, 0, 0);
    tick(2);
    check("ring.lat0", 32'(ring), 32'h0);
    idle(1);
    check("ring.on", 32'(ring), 32'h1);
    tick(6);
    check("ring.auto_off", 32'(ring), 32'h0);

    cyc("reld", 0, 1, 16'h0004, 0, 16'h0, 0, 0);
    tick(2);
    idle(1);
    check("ring.on2", 32'(ring), 32'h1);
    cyc("ack", 0, 0, 16'h0, 0, 16'h0, 1, 0);
    check("ack.off", 32'(ring), 32'h0);
    idle(3);
    check("ack.noretrig", 32'(ring), 32'h0);

    cyc("reld", 0, 1, 16'h0004, 0, 16'h0, 0, 0);
    tick(2);
    idle(1);
    cyc("snz", 0, 0, 16'h0, 0, 16'h0, 0, 1);
`ifdef SNOOZE_EN
    check("snz.off", 32'(ring), 32'h0);
    tick(4);
    check("snz.back_on", 32'(ring), 32'h1);
`else
    check("snz.ignored", 32'(ring), 32'h1);
`endif
    reset = 1;
    idle(1);
    reset = 0;
    check("rst_ring.ring", 32'(ring), 32'h0);
    check("rst_ring.time", 32'(time_bcd), 32'h0);
    check("rst_ring.alarm", 32'(alarm_bcd), 32'h0);

    // Randomized phase, alarms biased close to the current time so rings occur.
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      tick_en     = ($urandom_range(0, 2) != 0);
      load        = ($urandom_range(0, 24) == 0);
      load_value  = ($urandom_range(0, 1) != 0) ? int2bcd($urandom_range(0, MODULUS - 1)) : 16'($urandom);
      alarm_load  = ($urandom_range(0, 19) == 0);
      alarm_value = ($urandom_range(0, 3) != 0) ? int2bcd((m_t + $urandom_range(1, 3)) % MODULUS)
                                                 : 16'($urandom);
      if ($urandom_range(0, 59) == 0) arm = ~arm;
      else if (!arm && $urandom_range(0, 9) == 0) arm = 1;
      ack    = ($urandom_range(0, 14) == 0);
      snooze = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
